// File: rtl/sm_phase_sequencer.sv
// sm_phase_sequencer: turns step pulses into coil phases, tracks position, aborts on stop/limits.
// Optional SM_IDLE_RELEASE_EN de-energises the coils after RELEASE_CYCLES idle cycles.
module sm_phase_sequencer #(
    parameter int CNT_W = 16,
    parameter int POS_W = 32
`ifdef SM_IDLE_RELEASE_EN
    , parameter int RELEASE_CYCLES = 50_000_000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             half_step,
    input  logic             stop,
    input  logic             lim_fwd,
    input  logic             lim_rev,
    output logic             drv_enable_SM,
    output logic [3:0]       phase,
    output logic [POS_W-1:0] position,
    output logic [CNT_W-1:0] steps_left,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] PHASES [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                          4'b0100, 4'b1100, 4'b1000, 4'b1001};
    state_t state, state_n;
    logic [2:0] idx, idx_n, inc;
    logic dir, dir_n, half, half_n, ab, ab_n;
    logic [POS_W-1:0] pos_n;
    logic [CNT_W-1:0] left_n;
    logic step_q;
    logic [1:0] fwd_sync, rev_sync;
    logic accept, rise, abort;
    assign cmd_ready = state == IDLE;
    assign accept = cmd_valid & cmd_ready;
    assign rise = step_in & ~step_q;
    assign abort = stop | (dir & fwd_sync[1]) | (~dir & rev_sync[1]);
    assign inc = half ? 3'd1 : 3'd2;
    assign drv_enable_SM = state == RUN;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign aborted = done & ab;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            dir        <= 1'b0;
            half       <= 1'b0;
            ab         <= 1'b0;
            position   <= '0;
            steps_left <= '0;
            step_q     <= 1'b0;
            fwd_sync   <= '0;
            rev_sync   <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            dir        <= dir_n;
            half       <= half_n;
            ab         <= ab_n;
            position   <= pos_n;
            steps_left <= left_n;
            step_q     <= step_in;
            fwd_sync   <= {fwd_sync[0], lim_fwd};
            rev_sync   <= {rev_sync[0], lim_rev};
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        dir_n   = dir;
        half_n  = half;
        ab_n    = ab;
        pos_n   = position;
        left_n  = steps_left;
        case (state)
            IDLE: if (accept) begin
                state_n = cmd_steps == '0 ? DONE : RUN;
                left_n  = cmd_steps;
                dir_n   = cmd_dir;
                half_n  = half_step;
                ab_n    = 1'b0;
            end
            // an abort in the same cycle as a rise discards the step
            RUN: if (abort) begin
                state_n = DONE;
                ab_n    = 1'b1;
            end else if (rise) begin
                idx_n   = dir ? idx + inc : idx - inc;
                pos_n   = dir ? position + 1'b1 : position - 1'b1;
                left_n  = steps_left - 1'b1;
                state_n = steps_left == CNT_W'(1) ? DONE : RUN;
            end
            default: state_n = IDLE;
        endcase
    end
`ifdef SM_IDLE_RELEASE_EN
    logic [31:0] idle_cnt;
    always_ff @(posedge clk) begin
        if (rst || state != IDLE || accept)
            idle_cnt <= '0;
        else if (idle_cnt != 32'(RELEASE_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
    end
    assign phase = idle_cnt == 32'(RELEASE_CYCLES) ? 4'b0000 : PHASES[idx];
`else
    assign phase = PHASES[idx];
`endif
endmodule

// File: tb/tb_sm_phase_sequencer.sv
// tb_sm_phase_sequencer: random move commands checked against an index/position model.
module tb_sm_phase_sequencer;
    logic clk = 0, rst = 1, step_in = 0, cmd_valid = 0, cmd_dir = 0, half_step = 0;
    logic stop = 0, lim_fwd = 0, lim_rev = 0;
    logic [15:0] cmd_steps = 0;
    logic cmd_ready, drv_enable_SM, busy, done, aborted;
    logic [3:0] phase;
    logic [31:0] position;
    logic [15:0] steps_left;
    int n_tests = 0, n_fail = 0;
    int m_idx = 0, m_pos = 0;
    logic [3:0] ptab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0100, 4'b1100, 4'b1000, 4'b1001};

    sm_phase_sequencer #(.CNT_W(16), .POS_W(32)
`ifdef SM_IDLE_RELEASE_EN
        , .RELEASE_CYCLES(8)
`endif
    ) dut (.clk(clk), .rst(rst), .step_in(step_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
           .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .half_step(half_step), .stop(stop),
           .lim_fwd(lim_fwd), .lim_rev(lim_rev), .drv_enable_SM(drv_enable_SM), .phase(phase),
           .position(position), .steps_left(steps_left), .busy(busy), .done(done), .aborted(aborted));

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle();
        check("idle_busy", busy, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_drv", drv_enable_SM, 0);
        check("idle_done", done, 0);
        check("idle_phase", phase, ptab[m_idx]);
        check("idle_pos", position, 32'(m_pos));
    endtask

    // kind: 0 stop, 1 limit in move direction, 2 limit opposite to motion (ignored)
    task automatic move(input int n, input bit d, input bit h, input int ab_at, input int kind, input bit hold);
        bit ended = 0;
        int stride = h ? 1 : 2;
        @(negedge clk);
        check("ready", cmd_ready, 1);
        cmd_valid = 1; cmd_steps = 16'(n); cmd_dir = d; half_step = h;
        if (kind == 2) begin
            if (d) lim_rev = 1; else lim_fwd = 1;
        end
        @(negedge clk);
        cmd_valid = hold; cmd_steps = 16'($urandom); cmd_dir = 1'($urandom); half_step = 1'($urandom);
        check("phase_acc", phase, ptab[m_idx]);
        check("busy", busy, 1);
        if (n == 0) begin
            check("zero_done", done, 1);
            check("zero_ab", aborted, 0);
            check("zero_drv", drv_enable_SM, 0);
            cmd_valid = 0;
        end else begin
            check("drv_on", drv_enable_SM, 1);
            for (int i = 0; i < n && !ended; i++) begin
                if (i == ab_at && kind != 2) begin
                    if (kind == 0) begin
                        stop = 1; step_in = 1;
                        @(negedge clk);
                        stop = 0; step_in = 0;
                    end else begin
                        if (d) lim_fwd = 1; else lim_rev = 1;
                        repeat (3) @(negedge clk);
                    end
                    check("ab_done", done, 1);
                    check("ab_flag", aborted, 1);
                    check("ab_drv", drv_enable_SM, 0);
                    check("ab_left", steps_left, 16'(n - i));
                    check("ab_phase", phase, ptab[m_idx]);
                    check("ab_pos", position, 32'(m_pos));
                    cmd_valid = 0;
                    ended = 1;
                end else begin
                    step_in = 1;
                    @(negedge clk);
                    m_idx = (m_idx + (d ? stride : 8 - stride)) % 8;
                    m_pos += d ? 1 : -1;
                    check("phase", phase, ptab[m_idx]);
                    check("pos", position, 32'(m_pos));
                    check("left", steps_left, 16'(n - i - 1));
                    check("done", done, i == n - 1);
                    check("drv", drv_enable_SM, i != n - 1);
                    if (i == n - 1) begin
                        check("ab_clear", aborted, 0);
                        cmd_valid = 0;
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    step_in = 0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
        end
        lim_fwd = 0; lim_rev = 0; step_in = 0; cmd_valid = 0;
        repeat (3) @(negedge clk);
        check_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_phase", phase, 4'b0001);
        check("rst_pos", position, 0);
        check("rst_left", steps_left, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_drv", drv_enable_SM, 0);
        check("rst_done", done, 0);
        check("rst_ab", aborted, 0);
`ifdef SM_IDLE_RELEASE_EN
        repeat (10) @(negedge clk);
        check("released", phase, 4'b0000);
`endif
        move(3, 1, 0, -1, 0, 0);
        move(2, 0, 1, -1, 0, 1);
        move(10, 1, 0, 4, 1, 0);
        move(10, 1, 1, -1, 2, 1);
        move(5, 0, 0, 2, 0, 0);
        move(0, 1, 0, -1, 0, 1);
        move(4, 0, 1, 0, 1, 0);
        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(0, 6);
            move(n, 1'($urandom), 1'($urandom), $urandom_range(0, n), $urandom_range(0, 3), 1'($urandom));
        end
        @(negedge clk);
        cmd_valid = 1; cmd_steps = 5; cmd_dir = 1; half_step = 0;
        @(negedge clk);
        cmd_valid = 0; step_in = 1;
        @(negedge clk);
        rst = 1; step_in = 0;
        @(negedge clk);
        rst = 0;
        m_idx = 0; m_pos = 0;
        check("mid_rst_phase", phase, 4'b0001);
        check("mid_rst_pos", position, 0);
        check("mid_rst_left", steps_left, 0);
        check_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
